multiclock_issuer: RTL and testbench

- Sits between the decode/execute stage and `multiclockalu`; it is the initiating side of the ALU's `is_multiclock_input`/`done` handshake.
- Accepts one M-extension request (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) from the pipeline and issues it to the ALU with a single-cycle start pulse.
- Stalls the pipeline until `done`, then presents the result with its destination register for one writeback cycle.
- Handles pipeline flush mid-operation and guards against stray `done` pulses after reset.

---
 rtl/multiclock_issuer_pkg.sv | 34 +++
 rtl/multiclock_issuer_cache.sv | 56 +++++
 rtl/multiclock_issuer.sv | 196 +++++++++++++++++++
 tb/tb_multiclock_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiclock_issuer_pkg.sv
// ============================================================================
// Module : multiclock_issuer_pkg
// Brief  : Shared definitions for the multiclock issuer: ALU_* operation codes
//          for the M-extension ops and the issuer FSM state encodings
//          (MCI_ST_*).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multiclock_issuer_pkg;

    // M-extension ALU operation codes, shared with the multiclock ALU.
    localparam logic [5:0] ALU_MUL    = 6'd20;
    localparam logic [5:0] ALU_MULH   = 6'd21;
    localparam logic [5:0] ALU_MULHSU = 6'd22;
    localparam logic [5:0] ALU_MULHU  = 6'd23;
    localparam logic [5:0] ALU_DIV    = 6'd24;
    localparam logic [5:0] ALU_DIVU   = 6'd25;
    localparam logic [5:0] ALU_REM    = 6'd26;
    localparam logic [5:0] ALU_REMU   = 6'd27;

    // Issuer FSM states.
    typedef enum logic [2:0] {
        MCI_ST_GUARD = 3'd0,
        MCI_ST_IDLE  = 3'd1,
        MCI_ST_ISSUE = 3'd2,
        MCI_ST_WAIT  = 3'd3,
        MCI_ST_DRAIN = 3'd4,
        MCI_ST_WB    = 3'd5
    } mci_state_t;

endpackage : multiclock_issuer_pkg

`default_nettype wire

// File: rtl/multiclock_issuer_cache.sv
// ============================================================================
// Module : muldiv_result_cache
// Brief  : Single-entry result cache {valid, alucode, op1, op2, result}.
//          Lookup is combinational; the entry is overwritten on every fill
//          and invalidated by reset.
// Ports  : clk, rst_n          clock / async active-low reset
//          i_code/i_op1/i_op2  lookup key (the incoming request)
//          o_hit, o_data       exact-match hit and the cached result
//          i_fill, i_fill_*    write strobe and the entry to store
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_result_cache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_code,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic        o_hit,
    output logic [31:0] o_data,
    input  logic        i_fill,
    input  logic [5:0]  i_fill_code,
    input  logic [31:0] i_fill_op1,
    input  logic [31:0] i_fill_op2,
    input  logic [31:0] i_fill_result
);

    logic        r_valid;
    logic [5:0]  r_code;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
        end else if (i_fill) begin
            r_valid  <= 1'b1;
            r_code   <= i_fill_code;
            r_op1    <= i_fill_op1;
            r_op2    <= i_fill_op2;
            r_result <= i_fill_result;
        end
    end

    assign o_hit  = r_valid && (r_code == i_code) && (r_op1 == i_op1) && (r_op2 == i_op2);
    assign o_data = r_result;

endmodule : muldiv_result_cache

`default_nettype wire

// File: rtl/multiclock_issuer.sv
// ============================================================================
// Module : multiclock_issuer
// Brief  : Issues one M-extension request at a time to the multiclock ALU
//          with a single-cycle start pulse, stalls the pipeline until the
//          ALU reports done, and presents the result for one writeback cycle.
//          Handles flush mid-operation and ignores stray done pulses for
//          RESET_GUARD cycles after reset.
// Config : MULDIV_RESULT_CACHE_EN - when defined, a single-entry result cache
//          lets an exact repeat of the last completed op skip the ALU.
// Ports  : clk, rst_n                       clock / async active-low reset
//          req_valid/alucode/op1/op2/rd      request from the pipeline
//          flush                             kill the in-flight request
//          stall                             freeze the upstream pipeline
//          wb_valid/wb_rd/wb_data            one-cycle writeback
//          alu_start/code/op1/op2            to the ALU
//          alu_result/alu_done               from the ALU
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiclock_issuer
    import multiclock_issuer_pkg::*;
#(
    parameter int RESET_GUARD = 40,
    parameter int GUARD_W     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        alu_start,
    output logic [5:0]  alu_code,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_done
);

    localparam logic [GUARD_W-1:0] c_GUARD_LAST = GUARD_W'(RESET_GUARD - 1);

    mci_state_t         r_state;
    mci_state_t         w_next;
    logic [GUARD_W-1:0] r_guard_cnt;
    logic [5:0]         r_code;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [4:0]         r_rd;
    logic [31:0]        r_wb_data;

    logic               w_latch;     // request accepted in IDLE
    logic               w_capture;   // WAIT -> WB with a live ALU result
    logic               w_stall;
    logic               w_start;
    logic               w_wb_valid;
    logic               w_hit;
    logic [31:0]        w_hit_data;

`ifdef MULDIV_RESULT_CACHE_EN
    muldiv_result_cache u_cache (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_code        (req_alucode),
        .i_op1         (req_op1),
        .i_op2         (req_op2),
        .o_hit         (w_hit),
        .o_data        (w_hit_data),
        .i_fill        (w_capture),
        .i_fill_code   (r_code),
        .i_fill_op1    (r_op1),
        .i_fill_op2    (r_op2),
        .i_fill_result (alu_result)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // State register and guard counter. The guard counter only runs in
    // GUARD, which is entered solely through reset, so it never needs an
    // explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MCI_ST_GUARD;
            r_guard_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MCI_ST_GUARD) begin
                r_guard_cnt <= r_guard_cnt + 1'b1;
            end
        end
    end

    // Holding registers feed the ALU directly, so they must not change
    // between ISSUE and the exit from WAIT/DRAIN; they load only in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code    <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_latch) begin
                r_code <= req_alucode;
                r_op1  <= req_op1;
                r_op2  <= req_op2;
                r_rd   <= req_rd;
            end
            if (w_latch && w_hit) begin
                r_wb_data <= w_hit_data;
            end else if (w_capture) begin
                r_wb_data <= alu_result;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_capture  = 1'b0;
        w_stall    = 1'b0;
        w_start    = 1'b0;
        w_wb_valid = 1'b0;
        case (r_state)
            MCI_ST_GUARD: begin
                // alu_done is deliberately ignored: a late done from an op
                // killed by reset must not be mistaken for a new result.
                w_stall = req_valid;
                if (r_guard_cnt == c_GUARD_LAST) begin
                    w_next = MCI_ST_IDLE;
                end
            end
            MCI_ST_IDLE: begin
                w_stall = req_valid;
                if (req_valid && !flush) begin
                    w_latch = 1'b1;
                    w_next  = w_hit ? MCI_ST_WB : MCI_ST_ISSUE;
                end
            end
            MCI_ST_ISSUE: begin
                // The pulse always completes, so the ALU is busy either way;
                // a flush here has to drain that operation.
                w_stall = 1'b1;
                w_start = 1'b1;
                w_next  = flush ? MCI_ST_DRAIN : MCI_ST_WAIT;
            end
            MCI_ST_WAIT: begin
                w_stall = 1'b1;
                if (alu_done) begin
                    if (flush) begin
                        w_next = MCI_ST_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = MCI_ST_WB;
                    end
                end else if (flush) begin
                    w_next = MCI_ST_DRAIN;
                end
            end
            MCI_ST_DRAIN: begin
                w_stall = 1'b1;
                if (alu_done) begin
                    w_next = MCI_ST_IDLE;
                end
            end
            MCI_ST_WB: begin
                // The stalled request retires this cycle; it is not re-accepted.
                w_wb_valid = 1'b1;
                w_next     = MCI_ST_IDLE;
            end
            default: begin
                w_next = MCI_ST_GUARD;
            end
        endcase
    end

    assign stall     = w_stall;
    assign alu_start = w_start;
    assign wb_valid  = w_wb_valid;
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;
    assign alu_code  = r_code;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;

endmodule : multiclock_issuer

`default_nettype wire

// File: tb/tb_multiclock_issuer.sv
// ============================================================================
// Module : tb_multiclock_issuer
// Brief  : Scoreboard bench for multiclock_issuer with a behavioural
//          multiclock ALU (MUL* 30 cycles, DIV* 8 cycles).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiclock_issuer;
    import multiclock_issuer_pkg::*;

    localparam int RG = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  req_alucode = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        stall, wb_valid, alu_start;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, alu_op1, alu_op2;
    logic [5:0]  alu_code;
    logic [31:0] alu_result = '0;
    logic        alu_done = 1'b0;

    always #5 clk = ~clk;

    multiclock_issuer #(.RESET_GUARD(RG), .GUARD_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_alucode(req_alucode),
        .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd), .flush(flush),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_start(alu_start), .alu_code(alu_code), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_done(alu_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic (RISC-V M semantics) ----------------
    function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (c)
            ALU_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            ALU_MULH:   begin p = sa * sb;                 return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub;                 return p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int alu_latency(input logic [5:0] c);
        return (c >= ALU_DIV) ? 8 : 30;
    endfunction

    // ---------------- behavioural ALU (not reset by rst_n) ----------------
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    always @(posedge clk) begin
        if (alu_start) begin
            m_cnt <= alu_latency(alu_code);
            m_res <= ref_alu(alu_code, alu_op1, alu_op2);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
        alu_done   <= (m_cnt == 1) && !alu_start;
        alu_result <= (m_cnt == 1) ? m_res : $urandom;
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          starts;
    } exp_t;
    exp_t sb_q[$];

    int          cyc = 0;
    int          start_cnt = 0;
    int          last_wb_cyc = -100;
    int          last_done_cyc = -100;
    bit          op_live = 1'b0;
    logic [5:0]  cap_code;
    logic [31:0] cap_op1, cap_op2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            op_live   = 1'b0;
            start_cnt = 0;
        end else begin
            if (alu_start) begin
                start_cnt++;
                chk("start_gap_after_wb", 32'(cyc - last_wb_cyc >= 2), 32'd1);
                op_live  = 1'b1;
                cap_code = alu_code;
                cap_op1  = alu_op1;
                cap_op2  = alu_op2;
            end
            if (alu_done && op_live) begin
                chk("alu_inputs_stable", {alu_op1 ^ cap_op1} | {alu_op2 ^ cap_op2} | 32'(alu_code ^ cap_code), 32'd0);
                last_done_cyc = cyc;
                op_live = 1'b0;
            end
            if (wb_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                    chk("alu_start_count", 32'(start_cnt), 32'(e.starts));
                    chk("stall_low_in_wb", 32'(stall), 32'd0);
                    if (e.starts == 1) chk("wb_one_cycle_after_done", 32'(cyc - last_done_cyc), 32'd1);
                end
                last_wb_cyc = cyc;
                start_cnt   = 0;
            end
            if (!stall && !wb_valid) start_cnt = 0;
        end
    end

    // ---------------- cache expectation model ----------------
    bit          cm_valid = 1'b0;
    logic [5:0]  cm_code;
    logic [31:0] cm_a, cm_b;

    function automatic int exp_starts(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_RESULT_CACHE_EN
        if (cm_valid && cm_code == c && cm_a == a && cm_b == b) return 0;
`endif
        return 1;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1. Holds the request until stall drops (the WB cycle).
    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          output int dly, output int n_wb);
        int st;
        st = exp_starts(c, a, b);
        sb_q.push_back('{rd: rd, data: exp, starts: st});
        if (st == 1) begin
            cm_valid = 1'b1; cm_code = c; cm_a = a; cm_b = b;
        end
        req_alucode = c; req_op1 = a; req_op2 = b; req_rd = rd; req_valid = 1'b1;
        dly  = -1;
        n_wb = 0;
        do begin
            @(negedge clk);
            n_wb++;
            if (alu_start && dly < 0) dly = n_wb;
        end while (stall && n_wb < 300);
        chk("stall_drops_only_at_wb", 32'(wb_valid), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_alu_ops", alu_op1 | alu_op2 | 32'(alu_code), 32'd0);
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            n++;
            ok = alu_start;
        end
        if (!ok) chk("alu_start_timeout", 32'd0, 32'd1);
    endtask

    localparam logic [5:0] c_codes [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                           ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    initial begin
        int dly, nwb, n;
        bit ok, stall_ok;

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        rst_n = 1'b1;

        // Directed MUL presented straight out of reset: held off by the guard.
        run_op(ALU_MUL, 32'h0000_3141, 32'h0000_5926, 5'd5, 32'h1126_E8A6, dly, nwb);
        chk("guard_then_start_delay", 32'(dly), 32'(RG + 2));

        // Back-to-back divides, including divide by zero.
        run_op(ALU_DIV, 32'hFFFF_FFEC, 32'd7, 5'd6, 32'hFFFF_FFFE, dly, nwb);
        chk("idle_accept_start_delay", 32'(dly), 32'd2);
        run_op(ALU_DIV, 32'd10, 32'd0, 5'd7, 32'hFFFF_FFFF, dly, nwb);
        chk("b2b_start_delay", 32'(dly), 32'd2);

        // Flush at WAIT cycle 5: result drained, no writeback.
        req_alucode = ALU_MUL; req_op1 = 32'h2718_2818; req_op2 = 32'h4590_4523;
        req_rd = 5'd8; req_valid = 1'b1;
        wait_start(ok);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        stall_ok = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!stall) stall_ok = 1'b0;
        end while (!alu_done && n < 100);
        chk("drain_stall_held", 32'(stall_ok), 32'd1);
        chk("drain_done_seen", 32'(alu_done), 32'd1);
        @(negedge clk);
        chk("drain_back_to_idle", 32'(stall), 32'd0);
        @(posedge clk);
        #1;

        // Reset at WAIT cycle 10; the late done lands inside the guard window.
        req_alucode = ALU_MUL; req_op1 = 32'h2718_2818; req_op2 = 32'h4590_4523;
        req_rd = 5'd3; req_valid = 1'b1;
        wait_start(ok);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0; req_valid = 1'b0;
        cm_valid = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(ALU_MULHU, 32'd12345678, 32'hFFFF_FFFF, 5'd9, 32'h00BC_614D, dly, nwb);
        chk("post_reset_guard_delay", 32'(dly), 32'(RG + 2));

        // MULH, identical MULH (cache candidate), then MUL on the same operands.
        run_op(ALU_MULH, 32'd12345678, 32'hFF69_4BC1, 5'd10, 32'hFFFF_911A, dly, nwb);
        run_op(ALU_MULH, 32'd12345678, 32'hFF69_4BC1, 5'd11, 32'hFFFF_911A, dly, nwb);
`ifdef MULDIV_RESULT_CACHE_EN
        chk("cache_hit_latency", 32'(nwb), 32'd2);
`endif
        run_op(ALU_MUL, 32'd12345678, 32'hFF69_4BC1, 5'd12, 32'h5985_35CE, dly, nwb);

        // Randomized traffic checked against the reference arithmetic.
        for (int i = 0; i < 16; i++) begin
            logic [5:0]  c;
            logic [31:0] a, b;
            c = c_codes[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(c, a, b, 5'($urandom), ref_alu(c, a, b), dly, nwb);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_multiclock_issuer

`default_nettype wire
